pipe_stage_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage RISC-V pipeline. It collects the load-use request from the hazard unit, taken branches from EX, multi-cycle mul/div handshakes, and data-memory wait. It resolves them by fixed priority into per-stage register enables and bubble/flush controls. A small FSM tracks in-flight mul/div operations with a timeout watchdog.

---
 rtl/pipe_ctrl_pkg.sv | 27 ++
 rtl/pipe_perf_cnt.sv | 19 +
 rtl/pipe_stage_ctrl.sv | 119 +++++++++++
 tb/tb_pipe_stage_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and control encodings for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_NORMAL   = stage_ctrl_t'(8'b11111_000);
    localparam stage_ctrl_t CTRL_FREEZE   = stage_ctrl_t'(8'b00000_000);
    localparam stage_ctrl_t CTRL_RESET    = stage_ctrl_t'(8'b00000_111);
    localparam stage_ctrl_t CTRL_LOAD_USE = stage_ctrl_t'(8'b00111_010);
    localparam stage_ctrl_t CTRL_BRANCH   = stage_ctrl_t'(8'b11111_110);
    localparam stage_ctrl_t CTRL_MD_STALL = stage_ctrl_t'(8'b00011_001);

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating event counter with synchronous active-low clear.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline with mul/div wait FSM.
// Performance counters are built only when PIPE_STAGE_CTRL_PERF_EN is defined.
module pipe_stage_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             LOAD_USE,
    input  logic             BRANCH_TAKEN,
    input  logic             MD_START,
    input  logic             MD_DONE,
    input  logic             MEM_BUSY,
    output logic             PC_EN,
    output logic             IF_ID_EN,
    output logic             ID_EX_EN,
    output logic             EX_MEM_EN,
    output logic             MEM_WB_EN,
    output logic             IF_ID_FLUSH,
    output logic             ID_EX_FLUSH,
    output logic             EX_MEM_FLUSH,
    output logic             MD_ERR,
    output logic             STATE,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam int unsigned TO_W = $clog2(MD_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MD_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_cnt_inc;
    logic            md_err_q, md_err_d;
    stage_ctrl_t     ctrl;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= RUN;
            to_cnt_q <= '0;
            md_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
            md_err_q <= md_err_d;
        end
    end

    assign to_cnt_inc = to_cnt_q + TO_W'(1);

    // The start cycle counts as one MD cycle, so the abort is decided on the
    // incremented count: MD_TIMEOUT stall cycles in total before MD_ERR.
    always_comb begin
        ctrl     = CTRL_NORMAL;
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        md_err_d = 1'b0;
        if (!RST_N) begin
            ctrl = CTRL_RESET;
        end else if (MEM_BUSY) begin
            ctrl = CTRL_FREEZE;
        end else if (state_q == MD_WAIT) begin
            if (MD_DONE) begin
                state_d = RUN;
            end else begin
                ctrl     = CTRL_MD_STALL;
                to_cnt_d = to_cnt_inc;
                if (to_cnt_inc == TO_LAST) begin
                    md_err_d = 1'b1;
                    state_d  = RUN;
                end
            end
        end else if (BRANCH_TAKEN) begin
            ctrl = CTRL_BRANCH;
        end else if (MD_START && !MD_DONE) begin
            ctrl     = CTRL_MD_STALL;
            state_d  = MD_WAIT;
            to_cnt_d = '0;
        end else if (LOAD_USE) begin
            ctrl = CTRL_LOAD_USE;
        end
    end

    assign PC_EN        = ctrl.pc_en;
    assign IF_ID_EN     = ctrl.if_id_en;
    assign ID_EX_EN     = ctrl.id_ex_en;
    assign EX_MEM_EN    = ctrl.ex_mem_en;
    assign MEM_WB_EN    = ctrl.mem_wb_en;
    assign IF_ID_FLUSH  = ctrl.if_id_flush;
    assign ID_EX_FLUSH  = ctrl.id_ex_flush;
    assign EX_MEM_FLUSH = ctrl.ex_mem_flush;
    assign MD_ERR       = md_err_q & RST_N;
    assign STATE        = state_q;

`ifdef PIPE_STAGE_CTRL_PERF_EN
    logic branch_flush;

    assign branch_flush = RST_N && !MEM_BUSY && (state_q == RUN) && BRANCH_TAKEN;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (CLK),
        .clr_n (RST_N),
        .inc   (~ctrl.pc_en),
        .cnt   (STALL_CNT)
    );

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (CLK),
        .clr_n (RST_N),
        .inc   (branch_flush),
        .cnt   (FLUSH_CNT)
    );
`else
    assign STALL_CNT = '0;
    assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Scoreboard bench for pipe_stage_ctrl (MD_TIMEOUT=8, CNT_W=4) with directed vectors.
module tb_pipe_stage_ctrl;

    logic       CLK = 1'b0;
    logic       RST_N, LOAD_USE, BRANCH_TAKEN, MD_START, MD_DONE, MEM_BUSY;
    logic       PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN;
    logic       IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MD_ERR, STATE;
    logic [3:0] STALL_CNT, FLUSH_CNT;

    pipe_stage_ctrl #(.MD_TIMEOUT(8), .CNT_W(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .LOAD_USE(LOAD_USE), .BRANCH_TAKEN(BRANCH_TAKEN),
        .MD_START(MD_START), .MD_DONE(MD_DONE), .MEM_BUSY(MEM_BUSY),
        .PC_EN(PC_EN), .IF_ID_EN(IF_ID_EN), .ID_EX_EN(ID_EX_EN), .EX_MEM_EN(EX_MEM_EN),
        .MEM_WB_EN(MEM_WB_EN), .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH),
        .EX_MEM_FLUSH(EX_MEM_FLUSH), .MD_ERR(MD_ERR), .STATE(STATE),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    always #5 CLK = ~CLK;

`ifdef PIPE_STAGE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Inputs {LOAD_USE, BRANCH_TAKEN, MD_START, MD_DONE, MEM_BUSY}
    localparam logic [4:0] I0 = 5'b00000, LU = 5'b10000, BR = 5'b01000,
                           MS = 5'b00100, MD = 5'b00010, MB = 5'b00001;
    // Controls {PC,IF_ID,ID_EX,EX_MEM,MEM_WB enables, IF_ID,ID_EX,EX_MEM flushes}
    localparam logic [7:0] C_NORM = 8'b11111_000, C_FRZ = 8'b00000_000,
                           C_RST  = 8'b00000_111, C_LU  = 8'b00111_010,
                           C_BR   = 8'b11111_110, C_MD  = 8'b00011_001;

    typedef struct {
        logic [17:0] v;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    function automatic logic [3:0] pf(input int v);
        return PERF ? 4'(v) : 4'd0;
    endfunction

    task automatic step(input logic rst_n, input logic [4:0] in, input logic [7:0] c,
                        input logic s, input logic e, input int st, input int fl);
        exp_t x;
        RST_N = rst_n;
        {LOAD_USE, BRANCH_TAKEN, MD_START, MD_DONE, MEM_BUSY} = in;
        step_id++;
        x.v  = {c, s, e, pf(st), pf(fl)};
        x.id = step_id;
        sb.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            exp_t        x;
            logic [17:0] act;
            x   = sb.pop_front();
            act = {PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN, MEM_WB_EN, IF_ID_FLUSH,
                   ID_EX_FLUSH, EX_MEM_FLUSH, STATE, MD_ERR, STALL_CNT, FLUSH_CNT};
            checks++;
            if (act !== x.v) begin
                failures++;
                $display("FAIL step%0d ctrl/state/err/stall/flush: got %b/%b/%b/%h/%h required %b/%b/%b/%h/%h",
                         x.id, act[17:10], act[9], act[8], act[7:4], act[3:0],
                         x.v[17:10], x.v[9], x.v[8], x.v[7:4], x.v[3:0]);
            end
        end
    end

    initial begin
        RST_N = 1'b0;
        {LOAD_USE, BRANCH_TAKEN, MD_START, MD_DONE, MEM_BUSY} = I0;
        @(posedge CLK);
        #1;
        // reset, then idle
        step(0, I0,           C_RST,  0, 0, 0, 0);
        step(0, I0,           C_RST,  0, 0, 0, 0);
        step(1, I0,           C_NORM, 0, 0, 0, 0);
        // load-use bubble
        step(1, LU,           C_LU,   0, 0, 0, 0);
        step(1, I0,           C_NORM, 0, 0, 1, 0);
        // branch wins over load-use
        step(1, BR | LU,      C_BR,   0, 0, 1, 0);
        step(1, I0,           C_NORM, 0, 0, 1, 1);
        // 4-cycle mul/div; LOAD_USE/BRANCH ignored while waiting
        step(1, MS,           C_MD,   0, 0, 1, 1);
        step(1, MS,           C_MD,   1, 0, 2, 1);
        step(1, MS | LU | BR, C_MD,   1, 0, 3, 1);
        step(1, MS | MD,      C_NORM, 1, 0, 4, 1);
        step(1, I0,           C_NORM, 0, 0, 4, 1);
        // MEM_BUSY freeze inside MD_WAIT
        step(1, MS,           C_MD,   0, 0, 4, 1);
        step(1, MS,           C_MD,   1, 0, 5, 1);
        step(1, MS | MB,      C_FRZ,  1, 0, 6, 1);
        step(1, MS | MB,      C_FRZ,  1, 0, 7, 1);
        step(1, MS | MD,      C_NORM, 1, 0, 8, 1);
        step(1, I0,           C_NORM, 0, 0, 8, 1);
        // timeout after 8 MD cycles; stall counter saturates at 15
        step(1, MS,           C_MD,   0, 0, 8, 1);
        for (int i = 0; i < 7; i++)
            step(1, MS,       C_MD,   1, 0, 9 + i, 1);
        step(1, I0,           C_NORM, 0, 1, 15, 1);
        step(1, I0,           C_NORM, 0, 0, 15, 1);
        step(1, MB,           C_FRZ,  0, 0, 15, 1);
        step(1, MB | BR,      C_FRZ,  0, 0, 15, 1);
        step(1, I0,           C_NORM, 0, 0, 15, 1);
        // reset mid-MD_WAIT: back to RUN without MD_ERR
        step(1, MS,           C_MD,   0, 0, 15, 1);
        step(1, MS,           C_MD,   1, 0, 15, 1);
        step(0, MS,           C_RST,  1, 0, 15, 1);
        step(1, I0,           C_NORM, 0, 0, 0, 0);
        step(1, I0,           C_NORM, 0, 0, 0, 0);
        // single-cycle mul/div, then lone branch
        step(1, MS | MD,      C_NORM, 0, 0, 0, 0);
        step(1, I0,           C_NORM, 0, 0, 0, 0);
        step(1, BR,           C_BR,   0, 0, 0, 0);
        step(1, I0,           C_NORM, 0, 0, 0, 1);
        repeat (2) @(posedge CLK);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries required 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
